fib_sequencer: RTL
==================

Name: fib_sequencer

Overview:
- Hardware initiator for the Fib core; replaces bench-side reset pulsing and hierarchical N pokes.
- Accepts n requests over valid/ready, loads n into the core and holds the core in reset, then releases it.
- Waits for core completion and returns the result, with the n that produced it, over a valid/ready response port.
- Sits between the system request path and one Fib instance; a watchdog bounds every run.

Parameters:
- WORDSIZE, 32, width of core_result and rsp_result
- NWIDTH, 8, width of n
- RST_CYCLES, 2, cycles core_rst is held high in LOAD (min 1)
- TIMEOUT_CYCLES, 4096, maximum RUN cycles before abort (min 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer accepts request
- req_n  in  NWIDTH  requested n
- core_rst  out  1  active-high reset to Fib core
- core_n  out  NWIDTH  n presented to core
- core_ready  in  1  core done flag
- core_result  in  WORDSIZE  core result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  WORDSIZE  captured result
- rsp_n  out  NWIDTH  n of this response
- rsp_timeout  out  1  run aborted by watchdog

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, req_ready=1, core_rst=1 (core parked in reset)
  - core_n=0, rsp_valid=0, rsp_result=0, rsp_n=0, rsp_timeout=0, counters=0
- IDLE:
  - req_ready=1, core_rst=1.
  - Handshake when req_valid&req_ready: register req_n into core_n, go to LOAD, clear counter.
- LOAD:
  - req_ready=0, core_rst=1 for exactly RST_CYCLES cycles; core_n stable.
  - Then go to RUN with core_rst=0.
- RUN:
  - core_rst=0; core_n held stable.
  - Completion is a rising edge of core_ready (registered prev sample). prev is cleared on LOAD exit, so a core_ready already high at release does not count; the first cycle of RUN never completes.
  - On completion: capture core_result into rsp_result, core_n into rsp_n, rsp_timeout=0; go to RESP.
  - Watchdog: counts RUN cycles. On reaching TIMEOUT_CYCLES without completion: rsp_result=0, rsp_n=core_n, rsp_timeout=1, go to RESP.
  - A completion in the same cycle as expiry takes priority (timeout=0).
- RESP:
  - rsp_valid=1, core_rst=1 (core re-parked); outputs stable until rsp_valid&rsp_ready.
  - On handshake: rsp_valid=0, go to IDLE, req_ready=1 from the next cycle.
  - No same-cycle request acceptance in RESP.
- Latency: request accept to rsp_valid = RST_CYCLES + core run cycles + 1.
- Only one request is ever in flight; no buffering beyond the response register.
- rst assertion mid-run aborts immediately: response lost, core_rst=1.
- core_result is sampled only on the completion cycle; other changes are ignored.

Optional Feature:
- Macro FIB_SEQ_CYCLE_COUNT_EN.
- Defined: extra port rsp_cycles, out, 16 bits: number of RUN cycles for the run.
  - Saturates at 16'hFFFF.
  - Valid with rsp_valid; reset value 0.
  - On timeout equals TIMEOUT_CYCLES, saturated.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package fib_pkg:
  - state enum (IDLE, LOAD, RUN, RESP)
  - default WORDSIZE/NWIDTH constants
  - the timeout default
- One natural sub-module fib_seq_watchdog: loadable cycle counter with expire flag and saturating count output; also serves the optional cycle counter.
- Remaining control stays in fib_sequencer.

Test Plan:
- Nominal: behavioural core answers n=4 with 11 after 40 cycles -> exactly one rsp_valid with rsp_result=11, rsp_n=4, rsp_timeout=0; core_rst high for RST_CYCLES=2 cycles before the run.
- Back-to-back: requests n=5 then n=6, core results 53 and 309, rsp_ready held high -> responses in order; second req_ready only after first response handshake; core_rst pulses between runs.
- Backpressure: n=9, result 125361, rsp_ready held low 20 cycles -> rsp_valid and all rsp fields stable for all 20 cycles; req_valid ignored (req_ready=0); accepted on the rsp_ready cycle.
- Stale ready: core_ready tied high through LOAD and release, then low 5 cycles, then high -> completion only on the later rising edge.
- Timeout: TIMEOUT_CYCLES=16, core_ready never rises -> rsp_timeout=1, rsp_result=0 at RUN cycle 16; with FIB_SEQ_CYCLE_COUNT_EN, rsp_cycles=16.
- Mid-run reset: rst low during RUN -> all outputs at reset values asynchronously, no response; a new request after release completes normally.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fib core sequencer.
// Optional macro FIB_SEQ_CYCLE_COUNT_EN adds the rsp_cycles output to fib_sequencer.
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } seq_state_t;

    localparam int unsigned FIB_WORDSIZE       = 32;
    localparam int unsigned FIB_NWIDTH         = 8;
    localparam int unsigned FIB_RST_CYCLES     = 2;
    localparam int unsigned FIB_TIMEOUT_CYCLES = 4096;

    function automatic logic [15:0] sat16(input logic [31:0] value);
        return (value > 32'h0000_FFFF) ? 16'hFFFF : value[15:0];
    endfunction

endpackage

// File: rtl/fib_seq_watchdog.sv
// Loadable cycle counter with expire flag for the sequencer LOAD/RUN phases.
// With FIB_SEQ_CYCLE_COUNT_EN it also exports the saturated count of the current cycle.
module fib_seq_watchdog
    import fib_pkg::*;
#(
    parameter int unsigned CNT_W = 13,
    parameter int unsigned LIMIT = FIB_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             expire
`ifdef FIB_SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]      sat_count
`endif
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds completed cycles, so the LIMIT-th cycle is the one seeing LIMIT-1
    assign expire = (count == CNT_W'(LIMIT - 1));

`ifdef FIB_SEQ_CYCLE_COUNT_EN
    assign sat_count = sat16(32'(count) + 32'd1);
`endif

endmodule

// File: rtl/fib_sequencer.sv
// Request/response initiator for one Fib core: load n, pulse core reset, run, return result.
// Optional macro FIB_SEQ_CYCLE_COUNT_EN adds the rsp_cycles run-length output.
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int unsigned WORDSIZE       = FIB_WORDSIZE,
    parameter int unsigned NWIDTH         = FIB_NWIDTH,
    parameter int unsigned RST_CYCLES     = FIB_RST_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = FIB_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [NWIDTH-1:0]   req_n,
    output logic                core_rst,
    output logic [NWIDTH-1:0]   core_n,
    input  logic                core_ready,
    input  logic [WORDSIZE-1:0] core_result,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [WORDSIZE-1:0] rsp_result,
    output logic [NWIDTH-1:0]   rsp_n,
    output logic                rsp_timeout
`ifdef FIB_SEQ_CYCLE_COUNT_EN
    ,
    output logic [15:0]         rsp_cycles
`endif
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > RST_CYCLES) ? TIMEOUT_CYCLES : RST_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CNT_W-1:0] count;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expire;
    logic             prev_ready;
    logic             load_done;
    logic             complete;
`ifdef FIB_SEQ_CYCLE_COUNT_EN
    logic [15:0]      sat_count;
`endif

    // One counter times both the LOAD reset pulse and the RUN watchdog
    assign wd_clear  = (state == IDLE) || load_done;
    assign wd_enable = (state == LOAD) || (state == RUN);
    assign load_done = (state == LOAD) && (count == CNT_W'(RST_CYCLES - 1));

    // First RUN cycle is excluded so a level left high across release never completes
    assign complete  = (state == RUN) && (count != '0) && core_ready && !prev_ready;

    fib_seq_watchdog #(
        .CNT_W (CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear     (wd_clear),
        .enable    (wd_enable),
        .count     (count),
        .expire    (wd_expire)
`ifdef FIB_SEQ_CYCLE_COUNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        core_rst   = 1'b1;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) next_state = LOAD;
            end
            LOAD: begin
                if (load_done) next_state = RUN;
            end
            RUN: begin
                core_rst = 1'b0;
                if (complete || wd_expire) next_state = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_n      <= '0;
            prev_ready  <= 1'b0;
            rsp_result  <= '0;
            rsp_n       <= '0;
            rsp_timeout <= 1'b0;
`ifdef FIB_SEQ_CYCLE_COUNT_EN
            rsp_cycles  <= '0;
`endif
        end else begin
            if ((state == IDLE) && req_valid) begin
                core_n <= req_n;
            end

            if (state == LOAD) begin
                prev_ready <= 1'b0;
            end else if (state == RUN) begin
                prev_ready <= core_ready;
            end

            // Completion wins over a same-cycle watchdog expiry
            if (complete) begin
                rsp_result  <= core_result;
                rsp_n       <= core_n;
                rsp_timeout <= 1'b0;
`ifdef FIB_SEQ_CYCLE_COUNT_EN
                rsp_cycles  <= sat_count;
`endif
            end else if ((state == RUN) && wd_expire) begin
                rsp_result  <= '0;
                rsp_n       <= core_n;
                rsp_timeout <= 1'b1;
`ifdef FIB_SEQ_CYCLE_COUNT_EN
                rsp_cycles  <= sat_count;
`endif
            end
        end
    end

endmodule
